// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: checks controller state sequencing and dwell time, drives lamps.
// Pedestrian lamps are built only when TL_PED_EN is defined; otherwise ped_red/ped_green tie to 0.
module traffic_light_monitor #(
  parameter int TICK_DIV      = 50000000,
  parameter int WDOG_SEC      = 60,
  parameter int PED_DELAY     = 2,
  parameter int PED_BLINK_SEC = 35
) (
  input  logic       clk,
  input  logic       res,
  input  logic [1:0] state_in,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic       ped_red,
  output logic       ped_green,
  output logic       fault,
  output logic [6:0] elapsed_sec
);

  typedef enum logic [1:0] {
    ST_RED     = 2'd0,
    ST_YELLOW1 = 2'd1,
    ST_GREEN   = 2'd2,
    ST_YELLOW2 = 2'd3
  } tl_state_e;

  localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  if (TICK_DIV < 1 || WDOG_SEC < 1 || PED_BLINK_SEC < PED_DELAY) begin : g_bad_cfg
    $error("traffic_light_monitor: inconsistent timing parameters");
  end

  logic [PW-1:0] r_presc;
  logic          r_blink;
  tl_state_e     r_cur;
  logic [6:0]    r_elapsed;
  logic          r_fault;
  logic          r_lamp_r, r_lamp_y, r_lamp_g;

  logic [PW-1:0] w_presc_nxt;
  logic          w_tick;
  logic          w_blink_nxt;
  tl_state_e     w_cur_nxt;
  logic          w_trans;
  logic          w_legal;
  logic          w_wdog;
  logic [6:0]    w_elapsed_nxt;
  logic          w_fault_nxt;
  logic          w_lamp_r, w_lamp_y, w_lamp_g;

  assign w_tick      = (r_presc == PRESC_MAX);
  assign w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
  assign w_blink_nxt = r_blink ^ w_tick;
  assign w_cur_nxt   = tl_state_e'(state_in);
  assign w_trans     = (w_cur_nxt != r_cur);

  always_comb begin
    w_legal = 1'b0;
    case (r_cur)
      ST_RED:     w_legal = (w_cur_nxt == ST_YELLOW1) || (w_cur_nxt == ST_GREEN);
      ST_YELLOW1: w_legal = (w_cur_nxt == ST_GREEN);
      ST_GREEN:   w_legal = (w_cur_nxt == ST_YELLOW2);
      ST_YELLOW2: w_legal = (w_cur_nxt == ST_RED);
      default:    w_legal = 1'b0;
    endcase
  end

  // A transition in a tick cycle clears the counter and suppresses the watchdog.
  always_comb begin
    w_elapsed_nxt = r_elapsed;
    if (w_trans)
      w_elapsed_nxt = '0;
    else if (w_tick && r_elapsed != 7'd127)
      w_elapsed_nxt = r_elapsed + 7'd1;
  end

  assign w_wdog      = !w_trans && w_tick && (int'(r_elapsed) + 1 == WDOG_SEC);
  assign w_fault_nxt = r_fault || (w_trans && !w_legal) || w_wdog;

  // Lamps decode the next-cycle state so they line up with the registered state.
  always_comb begin
    w_lamp_r = 1'b0;
    w_lamp_y = 1'b0;
    w_lamp_g = 1'b0;
    if (w_fault_nxt) begin
      w_lamp_y = w_blink_nxt;
    end else begin
      case (w_cur_nxt)
        ST_RED:     w_lamp_r = 1'b1;
        ST_YELLOW1: begin w_lamp_r = 1'b1; w_lamp_y = 1'b1; end
        ST_GREEN:   w_lamp_g = 1'b1;
        ST_YELLOW2: w_lamp_y = 1'b1;
        default:    w_lamp_r = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      r_presc   <= '0;
      r_blink   <= 1'b0;
      r_cur     <= ST_RED;
      r_elapsed <= '0;
      r_fault   <= 1'b0;
      r_lamp_r  <= 1'b1;
      r_lamp_y  <= 1'b0;
      r_lamp_g  <= 1'b0;
    end else begin
      r_presc   <= w_presc_nxt;
      r_blink   <= w_blink_nxt;
      r_cur     <= w_cur_nxt;
      r_elapsed <= w_elapsed_nxt;
      r_fault   <= w_fault_nxt;
      r_lamp_r  <= w_lamp_r;
      r_lamp_y  <= w_lamp_y;
      r_lamp_g  <= w_lamp_g;
    end
  end

  assign lamp_red    = r_lamp_r;
  assign lamp_yellow = r_lamp_y;
  assign lamp_green  = r_lamp_g;
  assign fault       = r_fault;
  assign elapsed_sec = r_elapsed;

`ifdef TL_PED_EN
  logic r_ped_r, r_ped_g;
  logic w_ped_steady, w_ped_blinkwin;
  logic w_ped_r, w_ped_g;

  // Pedestrian green only ever exists in vehicle RED, so it cannot overlap green/yellow.
  assign w_ped_steady   = !w_fault_nxt && (w_cur_nxt == ST_RED) &&
                          (int'(w_elapsed_nxt) >= PED_DELAY) &&
                          (int'(w_elapsed_nxt) < PED_BLINK_SEC);
  assign w_ped_blinkwin = !w_fault_nxt && (w_cur_nxt == ST_RED) &&
                          (int'(w_elapsed_nxt) >= PED_BLINK_SEC);
  assign w_ped_g        = w_ped_steady || (w_ped_blinkwin && w_blink_nxt);
  assign w_ped_r        = !w_fault_nxt && !w_ped_steady && !w_ped_blinkwin;

  always_ff @(posedge clk) begin
    if (!res) begin
      r_ped_r <= 1'b1;
      r_ped_g <= 1'b0;
    end else begin
      r_ped_r <= w_ped_r;
      r_ped_g <= w_ped_g;
    end
  end

  assign ped_red   = r_ped_r;
  assign ped_green = r_ped_g;
`else
  assign ped_red   = 1'b0;
  assign ped_green = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor at TICK_DIV=4, WDOG_SEC=10, PED_DELAY=2, PED_BLINK_SEC=5.
module tb_traffic_light_monitor;

`ifdef TL_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic [1:0] state_in = 2'd0;
  logic       lamp_red, lamp_yellow, lamp_green, ped_red, ped_green, fault;
  logic [6:0] elapsed_sec;
  logic [5:0] obs;
  int total = 0;
  int bad   = 0;

  traffic_light_monitor #(
    .TICK_DIV(4), .WDOG_SEC(10), .PED_DELAY(2), .PED_BLINK_SEC(5)
  ) dut (
    .clk(clk), .res(res), .state_in(state_in),
    .lamp_red(lamp_red), .lamp_yellow(lamp_yellow), .lamp_green(lamp_green),
    .ped_red(ped_red), .ped_green(ped_green), .fault(fault), .elapsed_sec(elapsed_sec)
  );

  always #5 clk = ~clk;

  // {lamp_red, lamp_yellow, lamp_green, ped_red, ped_green, fault}
  assign obs = {lamp_red, lamp_yellow, lamp_green, ped_red, ped_green, fault};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the DUT just out of reset with state_in=RED; later step(k) means k live edges.
  task automatic do_reset();
    res = 1'b0; state_in = 2'd0;
    step(1);
    res = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    res = 1'b0; state_in = 2'd3;
    step(2);
    exp = {3'b100, PED, 1'b0, 1'b0};
    total++; if (obs !== exp) begin bad++; $display("FAIL reset_outs got=%b want=%b", obs, exp); end
    total++; if (elapsed_sec !== 7'd0) begin bad++; $display("FAIL reset_elapsed got=%0d want=0", elapsed_sec); end
    state_in = 2'd0;
    res = 1'b1;
  endtask

  task automatic test_ped_window();
    logic [5:0] exp;
    do_reset();
    step(1);
    exp = {3'b100, PED, 1'b0, 1'b0};
    total++; if (obs !== exp) begin bad++; $display("FAIL pedwin_start got=%b want=%b", obs, exp); end
    step(7);
    total++; if (elapsed_sec !== 7'd2) begin bad++; $display("FAIL pedwin_elapsed got=%0d want=2", elapsed_sec); end
    exp = {3'b100, 1'b0, PED, 1'b0};
    total++; if (obs !== exp) begin bad++; $display("FAIL pedwin_green got=%b want=%b", obs, exp); end
  endtask

  task automatic test_legal_cycle();
    logic [1:0] seq [4]   = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [2:0] lamps [4] = '{3'b110, 3'b001, 3'b010, 3'b100};
    logic [5:0] exp;
    do_reset();
    step(12);
    total++; if (elapsed_sec !== 7'd3) begin bad++; $display("FAIL cycle_red_hold got=%0d want=3", elapsed_sec); end
    for (int i = 0; i < 4; i++) begin
      state_in = seq[i];
      step(1);
      exp = {lamps[i], PED, 1'b0, 1'b0};
      total++; if (obs !== exp) begin bad++; $display("FAIL cycle_lamps_%0d got=%b want=%b", i, obs, exp); end
      total++; if (elapsed_sec !== 7'd0) begin bad++; $display("FAIL cycle_clear_%0d got=%0d want=0", i, elapsed_sec); end
      step(11);
      total++; if (elapsed_sec !== 7'd3 || fault !== 1'b0) begin
        bad++; $display("FAIL cycle_hold_%0d elapsed=%0d fault=%b want 3/0", i, elapsed_sec, fault);
      end
    end
  endtask

  task automatic test_shortcut();
    logic [5:0] exp;
    do_reset();
    step(2);
    state_in = 2'd2;
    step(1);
    exp = {3'b001, PED, 1'b0, 1'b0};
    total++; if (obs !== exp) begin bad++; $display("FAIL shortcut_green got=%b want=%b", obs, exp); end
    state_in = 2'd0;
    step(1);
    total++; if (obs !== 6'b010001) begin bad++; $display("FAIL illegal_fault got=%b want=010001", obs); end
    total++; if (elapsed_sec !== 7'd0) begin bad++; $display("FAIL illegal_elapsed got=%0d want=0", elapsed_sec); end
    step(4);
    total++; if (obs !== 6'b000001) begin bad++; $display("FAIL fault_blink_off got=%b want=000001", obs); end
    state_in = 2'd1;
    step(4);
    total++; if (obs !== 6'b010001) begin bad++; $display("FAIL fault_blink_on got=%b want=010001", obs); end
  endtask

  task automatic test_watchdog();
    logic [5:0] exp;
    do_reset();
    state_in = 2'd2;
    step(1);
    exp = {3'b001, PED, 1'b0, 1'b0};
    total++; if (obs !== exp) begin bad++; $display("FAIL wdog_green got=%b want=%b", obs, exp); end
    step(38);
    total++; if (elapsed_sec !== 7'd9 || fault !== 1'b0) begin
      bad++; $display("FAIL wdog_pre elapsed=%0d fault=%b want 9/0", elapsed_sec, fault);
    end
    step(1);
    total++; if (elapsed_sec !== 7'd10) begin bad++; $display("FAIL wdog_elapsed got=%0d want=10", elapsed_sec); end
    total++; if (obs !== 6'b000001) begin bad++; $display("FAIL wdog_fault got=%b want=000001", obs); end

    do_reset();
    state_in = 2'd2;
    step(39);
    total++; if (elapsed_sec !== 7'd9 || fault !== 1'b0) begin
      bad++; $display("FAIL wdog_race_pre elapsed=%0d fault=%b want 9/0", elapsed_sec, fault);
    end
    state_in = 2'd3;
    step(1);
    exp = {3'b010, PED, 1'b0, 1'b0};
    total++; if (obs !== exp) begin bad++; $display("FAIL wdog_race_outs got=%b want=%b", obs, exp); end
    total++; if (elapsed_sec !== 7'd0) begin bad++; $display("FAIL wdog_race_elapsed got=%0d want=0", elapsed_sec); end
    step(3);
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL wdog_race_after got=%b want=0", fault); end
  endtask

  task automatic test_ped_blink();
    logic [5:0] exp;
    do_reset();
    step(16);
    exp = {3'b100, 1'b0, PED, 1'b0};
    total++; if (obs !== exp || elapsed_sec !== 7'd4) begin
      bad++; $display("FAIL pedblk_e4 got=%b/%0d want=%b/4", obs, elapsed_sec, exp);
    end
    step(4);
    total++; if (obs !== exp || elapsed_sec !== 7'd5) begin
      bad++; $display("FAIL pedblk_e5 got=%b/%0d want=%b/5", obs, elapsed_sec, exp);
    end
    step(4);
    total++; if (obs !== 6'b100000) begin bad++; $display("FAIL pedblk_e6 got=%b want=100000", obs); end
    step(4);
    total++; if (obs !== exp) begin bad++; $display("FAIL pedblk_e7 got=%b want=%b", obs, exp); end
    state_in = 2'd3;
    step(1);
    total++; if (obs !== 6'b010001) begin bad++; $display("FAIL pedblk_fault got=%b want=010001", obs); end
    res = 1'b0;
    step(1);
    exp = {3'b100, PED, 1'b0, 1'b0};
    total++; if (obs !== exp || elapsed_sec !== 7'd0) begin
      bad++; $display("FAIL midfault_reset got=%b/%0d want=%b/0", obs, elapsed_sec, exp);
    end
    res = 1'b1; state_in = 2'd0;
    step(3);
    total++; if (elapsed_sec !== 7'd0) begin bad++; $display("FAIL presc_restart3 got=%0d want=0", elapsed_sec); end
    step(1);
    total++; if (elapsed_sec !== 7'd1 || fault !== 1'b0) begin
      bad++; $display("FAIL presc_restart4 elapsed=%0d fault=%b want 1/0", elapsed_sec, fault);
    end
  endtask

  task automatic test_post_reset();
    logic [5:0] exp;
    res = 1'b0; state_in = 2'd1;
    step(1);
    res = 1'b1;
    step(1);
    exp = {3'b110, PED, 1'b0, 1'b0};
    total++; if (obs !== exp) begin bad++; $display("FAIL postrst_legal got=%b want=%b", obs, exp); end
    res = 1'b0; state_in = 2'd3;
    step(1);
    res = 1'b1;
    step(1);
    total++; if (obs !== 6'b000001) begin bad++; $display("FAIL postrst_illegal got=%b want=000001", obs); end
  endtask

  initial begin
    test_reset();
    test_ped_window();
    test_legal_cycle();
    test_shortcut();
    test_watchdog();
    test_ped_blink();
    test_post_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
